// File: rtl/pingpang_ctrl_if.sv
// pingpang_ctrl_if: producer/consumer handshake and bank-steering signals of the ping-pong controller
interface pingpang_ctrl_if #(parameter int AW = 4);
  logic          in_valid, in_ready, wr_en, wr_bank;
  logic          rd_en, rd_bank, out_ready, out_valid, out_last;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    bank_full;
  modport master (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr, wr_bank, rd_en, rd_addr, rd_bank, out_valid, out_last, bank_full
  );
  modport slave (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr, wr_bank, rd_en, rd_addr, rd_bank, out_valid, out_last, bank_full
  );
endinterface

// File: rtl/pingpang_ctrl.sv
// pingpang_ctrl: steers a write stream into two banks and drains full banks in fill order
module pingpang_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic           clk,
  input logic           rst,
  pingpang_ctrl_if.slave bus
);
  typedef enum logic {IDLE, DRAIN} state_t;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t        r_state;
  logic [AW-1:0] r_wr_cnt, r_rd_cnt;
  logic          r_wr_bank, r_rd_bank, r_out_valid, r_out_last;
  logic [1:0]    r_full, w_set, w_clr;
  logic          w_in_ready, w_wr_en, w_rd_en, w_wr_wrap, w_rd_wrap;
  always_comb begin
    w_in_ready = ~r_full[r_wr_bank];
    w_wr_en    = bus.in_valid & w_in_ready;
    w_rd_en    = (r_state == DRAIN) & bus.out_ready;
    w_wr_wrap  = w_wr_en & (r_wr_cnt == LAST);
    w_rd_wrap  = w_rd_en & (r_rd_cnt == LAST);
    w_set      = w_wr_wrap ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    w_clr      = w_rd_wrap ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_full      <= (r_full & ~w_clr) | w_set;
      r_out_valid <= w_rd_en;
      r_out_last  <= w_rd_wrap;
      if (w_wr_en) begin
        r_wr_cnt <= w_wr_wrap ? '0 : r_wr_cnt + 1'b1;
        if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
      end
      if (r_state == IDLE) begin
        if (r_full[r_rd_bank]) begin
          r_state  <= DRAIN;
          r_rd_cnt <= '0;
        end
      end else if (w_rd_en) begin
        r_rd_cnt <= w_rd_wrap ? '0 : r_rd_cnt + 1'b1;
        if (w_rd_wrap) begin
          r_rd_bank <= ~r_rd_bank;
          r_state   <= IDLE;
        end
      end
    end
  end
  assign bus.in_ready  = w_in_ready;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_addr   = r_wr_cnt;
  assign bus.wr_bank   = r_wr_bank;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = r_rd_cnt;
  assign bus.rd_bank   = r_rd_bank;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.bank_full = r_full;
endmodule
